// File: rtl/mac_arbiter.sv
// mac_arbiter -- round-robin ownership arbiter in front of one mul_acc unit.
//
// A requester raises req and keeps it high for a whole sequence of ops. The
// arbiter grants ownership round-robin, forwards the owner's operands to the
// shared multiply-accumulate unit, routes op-done back to the owner and flags
// protocol violations. Only one op is in flight at a time.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   req[NREQ]         ownership request (level)
//   gnt[NREQ]         one-hot ownership grant (registered)
//   iv[NREQ]          op issue strobe
//   a, b[16*NREQ]     packed operands, slice n belongs to requester n
//   a_sb[NREQ]        1 = add, 0 = subtract
//   clr[NREQ]         clear accumulator with this op
//   ov[NREQ]          op-done, owner only
//   s[16]             accumulator value (broadcast of m_s)
//   m_iv/m_a/m_b/m_a_sb/m_clr   op to mul_acc
//   m_ov, m_s         op-done and accumulator from mul_acc
//   fault, fault_src  one-cycle protocol fault pulse and offending index
module mac_arbiter #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    output logic [NREQ-1:0]    gnt,
    input  logic [NREQ-1:0]    iv,
    input  logic [16*NREQ-1:0] a,
    input  logic [16*NREQ-1:0] b,
    input  logic [NREQ-1:0]    a_sb,
    input  logic [NREQ-1:0]    clr,
    output logic [NREQ-1:0]    ov,
    output logic [15:0]        s,
    output logic               m_iv,
    output logic [15:0]        m_a,
    output logic [15:0]        m_b,
    output logic               m_a_sb,
    output logic               m_clr,
    input  logic               m_ov,
    input  logic [15:0]        m_s,
    output logic               fault,
    output logic [1:0]         fault_src
);
    localparam int IW  = $clog2(NREQ);
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, OWN, OP} state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   own_q, own_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [WDW-1:0]  wd_q, wd_d;
    logic            first_q, first_d;   // next op is the first since grant
    logic            fault_q, fault_d;
    logic [1:0]      fsrc_q, fsrc_d;

    logic [IW:0]     pick_idle, pick_hand;
    logic [IW-1:0]   own_nxt;
    logic            own_req, own_iv, rel;
    logic [NREQ-1:0] fvec;

    // First set bit of mask at or after start, wrapping. Returns {found, index}.
    function automatic logic [IW:0] rr_pick(input logic [NREQ-1:0] mask,
                                            input logic [IW-1:0]   start);
        logic [IW:0]   r;
        logic [IW-1:0] k;
        r = '0;
        // Walk farthest-first so the nearest hit overwrites.
        for (int i = NREQ - 1; i >= 0; i--) begin
            k = IW'((int'(start) + i) % NREQ);
            if (mask[k]) r = {1'b1, k};
        end
        return r;
    endfunction

    assign own_nxt   = IW'((int'(own_q) + 1) % NREQ);
    assign own_req   = req[own_q];
    assign own_iv    = iv[own_q];
    assign pick_idle = rr_pick(req, ptr_q);
    // Handoff search starts past the releasing owner, whose req is already low.
    assign pick_hand = rr_pick(req, own_nxt);

    // Operands are steered by the owner index at all times; only m_iv/m_clr are gated.
    assign m_a       = a[16*int'(own_q) +: 16];
    assign m_b       = b[16*int'(own_q) +: 16];
    assign m_a_sb    = a_sb[own_q];
    assign s         = m_s;
    assign gnt       = gnt_q;
    assign fault     = fault_q;
    assign fault_src = fsrc_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        own_d   = own_q;
        ptr_d   = ptr_q;
        wd_d    = wd_q;
        first_d = first_q;
        m_iv    = 1'b0;
        m_clr   = 1'b0;
        ov      = '0;
        rel     = 1'b0;
        // Any issue from a non-owner is dropped and reported.
        fvec    = iv & ~gnt_q;

        case (state_q)
            IDLE: begin
                if (pick_idle[IW]) begin
                    state_d = OWN;
                    own_d   = pick_idle[IW-1:0];
                    gnt_d   = '0;
                    gnt_d[pick_idle[IW-1:0]] = 1'b1;
                    first_d = 1'b1;
                end
            end
            OWN: begin
                m_clr = clr[own_q];
                if (!own_req) begin
                    rel = 1'b1;
                end else if (own_iv) begin
                    m_iv    = 1'b1;
                    state_d = OP;
                    wd_d    = '0;
                    first_d = 1'b0;
                    // Forwarded anyway; the fault only reports the missing clear.
                    if (first_q && !clr[own_q]) fvec[own_q] = 1'b1;
                end
            end
            OP: begin
                wd_d = wd_q + 1'b1;
                if (own_iv) fvec[own_q] = 1'b1;
                if (m_ov) begin
                    ov[own_q] = 1'b1;
                    state_d   = OWN;
                    // Owner let go mid-op: finish delivery, then hand off at once.
                    if (!own_req) rel = 1'b1;
                end else if (wd_q == WDW'(TIMEOUT - 1)) begin
                    fvec[own_q] = 1'b1;
                    gnt_d       = '0;
                    state_d     = IDLE;
                    ptr_d       = own_nxt;
                end
            end
            default: state_d = IDLE;
        endcase

        if (rel) begin
            ptr_d = own_nxt;
            if (pick_hand[IW]) begin
                state_d = OWN;
                own_d   = pick_hand[IW-1:0];
                gnt_d   = '0;
                gnt_d[pick_hand[IW-1:0]] = 1'b1;
                first_d = 1'b1;
            end else begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        end

        fault_d = |fvec;
        fsrc_d  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (fvec[i]) fsrc_d = 2'(i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            own_q   <= '0;
            ptr_q   <= '0;
            wd_q    <= '0;
            first_q <= 1'b0;
            fault_q <= 1'b0;
            fsrc_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            own_q   <= own_d;
            ptr_q   <= ptr_d;
            wd_q    <= wd_d;
            first_q <= first_d;
            fault_q <= fault_d;
            fsrc_q  <= fsrc_d;
        end
    end

endmodule

// File: tb/tb_mac_arbiter.sv
// Directed bench for mac_arbiter (NREQ=2, TIMEOUT=15): a table of per-cycle
// input/expected-output records, then hand sequences for the watchdog and
// asynchronous reset during an op.
module tb_mac_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req, iv, a_sb, clr, gnt, ov;
    logic [31:0] a, b;
    logic [15:0] s, m_a, m_b, m_s;
    logic        m_iv, m_a_sb, m_clr, m_ov, fault;
    logic [1:0]  fault_src;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] opa [2];
    logic [15:0] opb [2];
    logic [1:0]  asb_c;

    mac_arbiter #(.NREQ(2), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .iv(iv), .a(a), .b(b),
        .a_sb(a_sb), .clr(clr), .ov(ov), .s(s), .m_iv(m_iv), .m_a(m_a),
        .m_b(m_b), .m_a_sb(m_a_sb), .m_clr(m_clr), .m_ov(m_ov), .m_s(m_s),
        .fault(fault), .fault_src(fault_src)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] req, iv, clr;
        logic       mov;
        logic [1:0] e_gnt, e_ov;
        logic       e_miv, e_mclr, e_flt;
        logic [1:0] e_fsrc;
        int         e_own;
    } vec_t;

    vec_t tbl [27];

    function automatic vec_t mk(input logic [1:0] rq, input logic [1:0] v,
                                input logic [1:0] c, input logic mo,
                                input logic [1:0] g, input logic [1:0] o,
                                input logic mi, input logic mc, input logic f,
                                input logic [1:0] fs, input int ow);
        vec_t t;
        t.req = rq; t.iv = v; t.clr = c; t.mov = mo;
        t.e_gnt = g; t.e_ov = o; t.e_miv = mi; t.e_mclr = mc;
        t.e_flt = f; t.e_fsrc = fs; t.e_own = ow;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] rq, input logic [1:0] v,
                         input logic [1:0] c, input logic mo, input logic [15:0] ms);
        @(negedge clk);
        req = rq; iv = v; clr = c; m_ov = mo; m_s = ms;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

    initial begin
        opa[0] = 16'h1000; opa[1] = 16'h2222;
        opb[0] = 16'h0800; opb[1] = 16'h3333;
        asb_c  = 2'b01;
        a = {opa[1], opa[0]};
        b = {opb[1], opb[0]};
        a_sb = asb_c;
        rst = 1'b1; req = '0; iv = 2'b11; clr = '0; m_ov = 1'b1; m_s = '0;

        //          req   iv    clr  mov  gnt   ov   miv mclr flt fsrc own
        tbl[0]  = mk(2'b00,2'b00,2'b00,1, 2'b00,2'b00,0,0,0,2'd0,0);
        tbl[1]  = mk(2'b01,2'b00,2'b00,0, 2'b00,2'b00,0,0,0,2'd0,0);
        tbl[2]  = mk(2'b01,2'b01,2'b01,0, 2'b01,2'b00,1,1,0,2'd0,0);
        tbl[3]  = mk(2'b01,2'b00,2'b01,0, 2'b01,2'b00,0,0,0,2'd0,0);
        tbl[4]  = mk(2'b01,2'b00,2'b01,1, 2'b01,2'b01,0,0,0,2'd0,0);
        tbl[5]  = mk(2'b01,2'b01,2'b00,0, 2'b01,2'b00,1,0,0,2'd0,0);
        tbl[6]  = mk(2'b01,2'b10,2'b00,0, 2'b01,2'b00,0,0,0,2'd0,0);
        tbl[7]  = mk(2'b01,2'b00,2'b00,1, 2'b01,2'b01,0,0,1,2'd1,0);
        tbl[8]  = mk(2'b00,2'b00,2'b00,0, 2'b01,2'b00,0,0,0,2'd0,0);
        tbl[9]  = mk(2'b11,2'b00,2'b00,0, 2'b00,2'b00,0,0,0,2'd0,0);
        tbl[10] = mk(2'b11,2'b10,2'b00,0, 2'b10,2'b00,1,0,0,2'd0,1);
        tbl[11] = mk(2'b11,2'b00,2'b00,0, 2'b10,2'b00,0,0,1,2'd1,1);
        tbl[12] = mk(2'b01,2'b00,2'b00,0, 2'b10,2'b00,0,0,0,2'd0,1);
        tbl[13] = mk(2'b01,2'b00,2'b00,1, 2'b10,2'b10,0,0,0,2'd0,1);
        tbl[14] = mk(2'b01,2'b00,2'b00,1, 2'b01,2'b00,0,0,0,2'd0,0);
        tbl[15] = mk(2'b11,2'b01,2'b01,0, 2'b01,2'b00,1,1,0,2'd0,0);
        tbl[16] = mk(2'b11,2'b00,2'b01,1, 2'b01,2'b01,0,0,0,2'd0,0);
        tbl[17] = mk(2'b10,2'b00,2'b00,0, 2'b01,2'b00,0,0,0,2'd0,0);
        tbl[18] = mk(2'b11,2'b00,2'b00,0, 2'b10,2'b00,0,0,0,2'd0,1);
        tbl[19] = mk(2'b01,2'b00,2'b00,0, 2'b10,2'b00,0,0,0,2'd0,1);
        tbl[20] = mk(2'b01,2'b00,2'b00,0, 2'b01,2'b00,0,0,0,2'd0,0);
        tbl[21] = mk(2'b01,2'b11,2'b01,0, 2'b01,2'b00,1,1,0,2'd0,0);
        tbl[22] = mk(2'b01,2'b01,2'b01,0, 2'b01,2'b00,0,0,1,2'd1,0);
        tbl[23] = mk(2'b01,2'b00,2'b01,1, 2'b01,2'b01,0,0,1,2'd0,0);
        tbl[24] = mk(2'b00,2'b00,2'b00,0, 2'b01,2'b00,0,0,0,2'd0,0);
        tbl[25] = mk(2'b00,2'b11,2'b00,0, 2'b00,2'b00,0,0,0,2'd0,0);
        tbl[26] = mk(2'b00,2'b00,2'b00,0, 2'b00,2'b00,0,0,1,2'd0,0);

        // Reset state, with issue and m_ov driven to show gating.
        #12;
        chk("rst gnt",       16'(gnt),       16'h0);
        chk("rst ov",        16'(ov),        16'h0);
        chk("rst m_iv",      16'(m_iv),      16'h0);
        chk("rst fault",     16'(fault),     16'h0);
        chk("rst fault_src", 16'(fault_src), 16'h0);
        @(negedge clk);
        rst = 1'b0; iv = '0; m_ov = 1'b0;

        for (int r = 0; r < 27; r++) begin
            logic [15:0] ms;
            ms = 16'hA000 + 16'(r);
            drive(tbl[r].req, tbl[r].iv, tbl[r].clr, tbl[r].mov, ms);
            chk($sformatf("r%0d gnt", r),       16'(gnt),       16'(tbl[r].e_gnt));
            chk($sformatf("r%0d ov", r),        16'(ov),        16'(tbl[r].e_ov));
            chk($sformatf("r%0d m_iv", r),      16'(m_iv),      16'(tbl[r].e_miv));
            chk($sformatf("r%0d m_clr", r),     16'(m_clr),     16'(tbl[r].e_mclr));
            chk($sformatf("r%0d fault", r),     16'(fault),     16'(tbl[r].e_flt));
            chk($sformatf("r%0d fault_src", r), 16'(fault_src), 16'(tbl[r].e_fsrc));
            chk($sformatf("r%0d m_a", r),       m_a,            opa[tbl[r].e_own]);
            chk($sformatf("r%0d m_b", r),       m_b,            opb[tbl[r].e_own]);
            chk($sformatf("r%0d m_a_sb", r),    16'(m_a_sb),    16'(asb_c[tbl[r].e_own]));
            chk($sformatf("r%0d s", r),         s,              ms);
        end

        // Watchdog: idle with pointer at 1, both requesting -> requester 1 owns.
        drive(2'b11, 2'b00, 2'b00, 1'b0, 16'h0);
        chk("wd pre gnt", 16'(gnt), 16'h0);
        drive(2'b11, 2'b00, 2'b00, 1'b0, 16'h0);
        chk("wd own gnt", 16'(gnt), 16'h2);
        drive(2'b11, 2'b10, 2'b10, 1'b0, 16'h0);
        chk("wd issue m_iv", 16'(m_iv), 16'h1);
        for (int k = 1; k <= 15; k++) begin
            drive(2'b11, 2'b00, 2'b10, 1'b0, 16'h0);
            chk($sformatf("wd c%0d fault", k), 16'(fault), 16'h0);
            chk($sformatf("wd c%0d gnt", k),   16'(gnt),   16'h2);
        end
        drive(2'b11, 2'b00, 2'b10, 1'b0, 16'h0);
        chk("wd fault",     16'(fault),     16'h1);
        chk("wd fault_src", 16'(fault_src), 16'h1);
        chk("wd gnt clr",   16'(gnt),       16'h0);
        drive(2'b11, 2'b00, 2'b00, 1'b0, 16'h0);
        chk("wd next owner", 16'(gnt), 16'h1);

        // Async reset in the middle of an op.
        drive(2'b01, 2'b11, 2'b01, 1'b0, 16'h0);
        chk("ar issue m_iv", 16'(m_iv), 16'h1);
        @(negedge clk);
        iv = 2'b01; m_ov = 1'b1;
        #1;
        chk("ar pre fault", 16'(fault), 16'h1);
        chk("ar pre ov",    16'(ov),    16'h1);
        chk("ar pre gnt",   16'(gnt),   16'h1);
        rst = 1'b1;
        #1;
        chk("ar gnt",   16'(gnt),   16'h0);
        chk("ar ov",    16'(ov),    16'h0);
        chk("ar m_iv",  16'(m_iv),  16'h0);
        chk("ar fault", 16'(fault), 16'h0);
        @(negedge clk);
        rst = 1'b0; req = 2'b01; iv = '0; m_ov = 1'b0; clr = '0;
        #1;
        chk("ar post gnt0", 16'(gnt), 16'h0);
        drive(2'b01, 2'b00, 2'b00, 1'b0, 16'h0);
        chk("ar post gnt1", 16'(gnt), 16'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
